// File: rtl/rr_mux4_arb.sv
// rr_mux4_arb: 4-channel round-robin arbiter feeding a registered 4:1 mux with a one-deep output stage.
// Define RR_MUX4_GRANT_CNT_EN to add the 8-bit grant_cnt output counting input transfers.
module rr_mux4_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] v,
    output logic [3:0] rdy,
    output logic [1:0] s,
    output logic [3:0] y,
    output logic       y_valid,
    input  logic       y_ready
`ifdef RR_MUX4_GRANT_CNT_EN
    ,
    output logic [7:0] grant_cnt
`endif
);

    // state | meaning
    // EMPTY | output stage holds no word, y_valid = 0
    // FULL  | y holds an unconsumed word, y_valid = 1
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] ptr;
    logic [1:0] g;
    logic [1:0] idx;
    logic [3:0] dg;
    logic       can_load;
    logic       load;

    // Walk the channels from ptr+3 down to ptr so the last hit is the first valid one after ptr.
    always_comb begin
        g   = ptr;
        idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + k[1:0];
            if (v[idx]) begin
                g = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rdy      = 4'b0000;
        load     = 1'b0;
        can_load = (state_q == EMPTY) | y_ready;
        if (!reset_n) begin
            state_d = EMPTY;
        end else if (can_load) begin
            if (|v) begin
                load    = 1'b1;
                rdy[g]  = 1'b1;
                state_d = FULL;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_comb begin
        case (g)
            2'd0:    dg = d0;
            2'd1:    dg = d1;
            2'd2:    dg = d2;
            default: dg = d3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            y       <= 4'h0;
            s       <= 2'b00;
            ptr     <= 2'b00;
        end else begin
            state_q <= state_d;
            if (load) begin
                y   <= dg;
                s   <= g;
                ptr <= g + 2'd1;
            end
        end
    end

    assign y_valid = (state_q == FULL);

`ifdef RR_MUX4_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_cnt <= 8'h00;
        end else if (load) begin
            grant_cnt <= grant_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux4_arb.sv
// Bench for rr_mux4_arb: behavioural model checked every cycle plus directed literal scenarios and random traffic.
module tb_rr_mux4_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] v;
    logic [3:0] rdy;
    logic [1:0] s;
    logic [3:0] y;
    logic       y_valid;
    logic       y_ready;
`ifdef RR_MUX4_GRANT_CNT_EN
    logic [7:0] grant_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state
    bit       m_full = 1'b0;
    int       m_ptr  = 0;
    int       m_s    = 0;
    int       m_y    = 0;
    int       m_cnt  = 0;

    rr_mux4_arb dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .v         (v),
        .rdy       (rdy),
        .s         (s),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready)
`ifdef RR_MUX4_GRANT_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // first valid channel at or after p, wrapping mod 4; -1 if none
    function automatic int first_from(input int p, input logic [3:0] vv);
        for (int k = 0; k < 4; k++) begin
            if (vv[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic int data_of(input int ch);
        case (ch)
            0:       return int'(d0);
            1:       return int'(d1);
            2:       return int'(d2);
            default: return int'(d3);
        endcase
    endfunction

    always @(posedge clk) begin
        int gi;
        if (!reset_n) begin
            m_full = 1'b0; m_ptr = 0; m_s = 0; m_y = 0; m_cnt = 0;
        end else if (!m_full || y_ready) begin
            gi = first_from(m_ptr, v);
            if (gi >= 0) begin
                m_y    = data_of(gi);
                m_s    = gi;
                m_ptr  = (gi + 1) % 4;
                m_full = 1'b1;
                m_cnt  = (m_cnt + 1) % 256;
            end else begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int gi;
        int exp_rdy;
        if (chk_en) begin
            exp_rdy = 0;
            gi = first_from(m_ptr, v);
            if (reset_n && (!m_full || y_ready) && gi >= 0) exp_rdy = 1 << gi;
            check("rdy", int'(rdy), exp_rdy);
            check("y_valid", int'(y_valid), int'(m_full));
            check("y", int'(y), m_y);
            check("s", int'(s), m_s);
`ifdef RR_MUX4_GRANT_CNT_EN
            check("grant_cnt", int'(grant_cnt), m_cnt);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; v = 4'h0; y_ready = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] lit_y [4];
        reset_n = 1'b0; v = 4'h0; y_ready = 1'b0;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
        step(3);
        chk_en = 1'b1;
        reset_n = 1'b1;

        // idle after reset
        v = 4'h0;
        step(5);
        check("idle_y_valid", int'(y_valid), 0);
        check("idle_rdy", int'(rdy), 0);
        check("idle_s", int'(s), 0);
        check("idle_y", int'(y), 0);

        // all channels valid, continuous drain: strict rotation
        lit_y[0] = 4'hA; lit_y[1] = 4'hB; lit_y[2] = 4'hC; lit_y[3] = 4'hD;
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        v = 4'hF; y_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("rot_y", int'(y), int'(lit_y[i % 4]));
            check("rot_s", int'(s), i % 4);
        end

        // drain, then a single grant to channel 3 held with y_ready low
        v = 4'h0; y_ready = 1'b1;
        step(1);
        check("drain_y_valid", int'(y_valid), 0);
        v = 4'h8; d3 = 4'h5; y_ready = 1'b0;
        step(3);
        check("hold_y", int'(y), 5);
        check("hold_s", int'(s), 3);
        check("hold_y_valid", int'(y_valid), 1);
        check("hold_rdy", int'(rdy), 0);
        // pointer wrapped to 0
        v = 4'hF; y_ready = 1'b1;
        step(1);
        check("wrap_s", int'(s), 0);
        check("wrap_y", int'(y), int'(d0));

        // two channels, y_ready toggling
        v = 4'h5;
        for (int i = 0; i < 8; i++) begin
            y_ready = (i % 2 == 0);
            step(1);
        end

        // reset while full and stalled
        v = 4'hF; y_ready = 1'b1;
        step(1);
        y_ready = 1'b0;
        step(1);
        check("pre_rst_y_valid", int'(y_valid), 1);
        reset_n = 1'b0;
        #1;
        check("rst_rdy", int'(rdy), 0);
        step(1);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_y", int'(y), 0);
        check("rst_s", int'(s), 0);
        reset_n = 1'b1; v = 4'hE; y_ready = 1'b1;
        step(1);
        check("post_rst_s", int'(s), 1);

`ifdef RR_MUX4_GRANT_CNT_EN
        do_reset();
        v = 4'hF; y_ready = 1'b1;
        step(257);
        check("cnt_257", int'(grant_cnt), 1);
`endif

        // random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 63) != 0);
            v       = 4'($urandom_range(0, 15));
            d0      = 4'($urandom_range(0, 15));
            d1      = 4'($urandom_range(0, 15));
            d2      = 4'($urandom_range(0, 15));
            d3      = 4'($urandom_range(0, 15));
            y_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
